// File: rtl/reg_array_mp.sv
// Multi-read-port integer register file with a per-register pending-write
// scoreboard, optional write-to-read bypass and a hardwired zero register.
module reg_array_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk_Regs,
  input  logic                         rst,
  input  logic                         Reg_Write,
  input  logic [ADDR_W-1:0]            W_Addr,
  input  logic [DATA_W-1:0]            W_Data,
  input  logic [NUM_READ*ADDR_W-1:0]   R_Addr,
  output logic [NUM_READ*DATA_W-1:0]   R_Data,
  output logic [NUM_READ-1:0]          R_Busy,
  input  logic                         Issue_Valid,
  input  logic [ADDR_W-1:0]            Issue_Addr,
  input  logic                         Flush,
  output logic [ADDR_W:0]              Busy_Count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic wr_ok;
  logic iss_ok;
  logic inc;
  logic dec;

  // Writes and issues to the zero register are silently dropped.
  assign wr_ok  = Reg_Write &&
                  !(ZR && (W_Addr == '0));
  assign iss_ok = Issue_Valid &&
                  !(ZR && (Issue_Addr == '0));

  // Count deltas: a new producer on an idle reg adds one, a write
  // retiring a busy reg removes one unless it is re-issued this cycle.
  assign inc = iss_ok && !busy[Issue_Addr];
  assign dec = wr_ok && busy[W_Addr] &&
               !(iss_ok && (Issue_Addr == W_Addr));

  // Next busy vector: clear on write, set wins, flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[W_Addr] = 1'b0;
    if (iss_ok)
      busy_nxt[Issue_Addr] = 1'b1;
    if (Flush)
      busy_nxt = '0;
  end

  // Next busy count tracked incrementally alongside the vector.
  always_comb begin
    cnt_nxt = Busy_Count;
    if (Flush)
      cnt_nxt = '0;
    else
      cnt_nxt = Busy_Count
              + {{ADDR_W{1'b0}}, inc}
              - {{ADDR_W{1'b0}}, dec};
  end

  // Register storage; writes land even during a flush.
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[W_Addr] <= W_Data;
    end
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      Busy_Count <= '0;
    end else begin
      busy       <= busy_nxt;
      Busy_Count <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra  = R_Addr[p*ADDR_W +: ADDR_W];
    assign hit = BP && wr_ok && (W_Addr == ra);

    // Combinational read with forwarding; quiet while in reset.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (!rst) begin
        if (ZR && (ra == '0)) begin
          rd = '0;
          rb = 1'b0;
        end else if (hit) begin
          rd = W_Data;
          rb = 1'b0;
        end else begin
          rd = mem[ra];
          rb = busy[ra];
        end
      end
    end

    assign R_Data[p*DATA_W +: DATA_W] = rd;
    assign R_Busy[p]                  = rb;
  end

endmodule

// File: tb/tb_reg_array_mp.sv
// Directed bench for reg_array_mp: one bypassing and one
// non-bypassing instance driven by the same stimulus.
module tb_reg_array_mp;

  logic        clk_Regs;
  logic        rst;
  logic        Reg_Write;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [9:0]  R_Addr;
  logic        Issue_Valid;
  logic [4:0]  Issue_Addr;
  logic        Flush;

  logic [63:0] R_Data;
  logic [1:0]  R_Busy;
  logic [5:0]  Busy_Count;
  logic [63:0] nb_data;
  logic [1:0]  nb_busy;
  logic [5:0]  nb_count;

  int total = 0;
  int bad   = 0;

  reg_array_mp u_dut (
    .clk_Regs(clk_Regs), .rst(rst),
    .Reg_Write(Reg_Write), .W_Addr(W_Addr),
    .W_Data(W_Data), .R_Addr(R_Addr),
    .R_Data(R_Data), .R_Busy(R_Busy),
    .Issue_Valid(Issue_Valid),
    .Issue_Addr(Issue_Addr), .Flush(Flush),
    .Busy_Count(Busy_Count)
  );

  reg_array_mp #(.BYPASS(0)) u_nb (
    .clk_Regs(clk_Regs), .rst(rst),
    .Reg_Write(Reg_Write), .W_Addr(W_Addr),
    .W_Data(W_Data), .R_Addr(R_Addr),
    .R_Data(nb_data), .R_Busy(nb_busy),
    .Issue_Valid(Issue_Valid),
    .Issue_Addr(Issue_Addr), .Flush(Flush),
    .Busy_Count(nb_count)
  );

  initial clk_Regs = 1'b0;
  always #5 clk_Regs = ~clk_Regs;

  task automatic tick();
    @(posedge clk_Regs);
    #1;
  endtask

  task automatic idle();
    Reg_Write   = 1'b0;
    Issue_Valid = 1'b0;
    Flush       = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (Busy_Count !== 6'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", Busy_Count);
    end
    total++;
    if (R_Data !== 64'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", R_Data);
    end
    total++;
    if (R_Busy !== 2'b00) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=00", R_Busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    Reg_Write = 1'b1; W_Addr = 5'd1;
    W_Data = 32'hFEDCBA98;
    tick();
    idle();
    R_Addr = {5'd1, 5'd1};
    #1;
    total++;
    if (R_Data[31:0] !== 32'hFEDCBA98) begin
      bad++;
      $display("FAIL wr_port0 got=%h exp=FEDCBA98", R_Data[31:0]);
    end
    total++;
    if (R_Data[63:32] !== 32'hFEDCBA98) begin
      bad++;
      $display("FAIL wr_port1 got=%h exp=FEDCBA98", R_Data[63:32]);
    end
    total++;
    if (nb_data[31:0] !== 32'hFEDCBA98) begin
      bad++;
      $display("FAIL wr_nb_port0 got=%h exp=FEDCBA98", nb_data[31:0]);
    end
  endtask

  task automatic test_zero();
    Reg_Write = 1'b1; W_Addr = 5'd0;
    W_Data = 32'h07643210;
    Issue_Valid = 1'b1; Issue_Addr = 5'd0;
    R_Addr = {5'd0, 5'd0};
    #1;
    total++;
    if (R_Data[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL zero_bypass got=%h exp=0", R_Data[31:0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (R_Data[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL zero_read got=%h exp=0", R_Data[31:0]);
    end
    total++;
    if (Busy_Count !== 6'd0) begin
      bad++;
      $display("FAIL zero_count got=%0d exp=0", Busy_Count);
    end
    total++;
    if (R_Busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_busy got=%b exp=0", R_Busy[0]);
    end
  endtask

  task automatic test_bypass();
    Reg_Write = 1'b1; W_Addr = 5'd5;
    W_Data = 32'h11111111;
    tick();
    idle();
    Issue_Valid = 1'b1; Issue_Addr = 5'd5;
    tick();
    idle();
    Reg_Write = 1'b1; W_Addr = 5'd5;
    W_Data = 32'h12345678;
    R_Addr = {5'd0, 5'd5};
    #1;
    total++;
    if (R_Data[31:0] !== 32'h12345678) begin
      bad++;
      $display("FAIL byp_data got=%h exp=12345678", R_Data[31:0]);
    end
    total++;
    if (nb_data[31:0] !== 32'h11111111) begin
      bad++;
      $display("FAIL nobyp_data got=%h exp=11111111", nb_data[31:0]);
    end
    total++;
    if (R_Busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL byp_busy got=%b exp=0", R_Busy[0]);
    end
    total++;
    if (nb_busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL nobyp_busy got=%b exp=1", nb_busy[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (nb_data[31:0] !== 32'h12345678) begin
      bad++;
      $display("FAIL nobyp_after got=%h exp=12345678", nb_data[31:0]);
    end
    total++;
    if (Busy_Count !== 6'd0) begin
      bad++;
      $display("FAIL byp_count got=%0d exp=0", Busy_Count);
    end
  endtask

  task automatic test_scoreboard();
    Issue_Valid = 1'b1; Issue_Addr = 5'd3;
    tick();
    Issue_Addr = 5'd4;
    tick();
    idle();
    R_Addr = {5'd4, 5'd3};
    #1;
    total++;
    if (Busy_Count !== 6'd2) begin
      bad++;
      $display("FAIL sb_count2 got=%0d exp=2", Busy_Count);
    end
    total++;
    if (R_Busy !== 2'b11) begin
      bad++;
      $display("FAIL sb_busy got=%b exp=11", R_Busy);
    end
    Reg_Write = 1'b1; W_Addr = 5'd3;
    W_Data = 32'h33;
    Issue_Valid = 1'b1; Issue_Addr = 5'd3;
    tick();
    idle();
    #1;
    total++;
    if (Busy_Count !== 6'd2) begin
      bad++;
      $display("FAIL sb_setwins_count got=%0d exp=2", Busy_Count);
    end
    total++;
    if (R_Busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL sb_setwins_bit got=%b exp=1", R_Busy[0]);
    end
    Reg_Write = 1'b1; W_Addr = 5'd4;
    W_Data = 32'h44;
    tick();
    idle();
    #1;
    total++;
    if (Busy_Count !== 6'd1) begin
      bad++;
      $display("FAIL sb_count1 got=%0d exp=1", Busy_Count);
    end
    total++;
    if (R_Busy !== 2'b01) begin
      bad++;
      $display("FAIL sb_busy_r4 got=%b exp=01", R_Busy);
    end
  endtask

  task automatic test_flush();
    Issue_Valid = 1'b1; Issue_Addr = 5'd7;
    tick();
    idle();
    #1;
    total++;
    if (Busy_Count !== 6'd2) begin
      bad++;
      $display("FAIL fl_pre got=%0d exp=2", Busy_Count);
    end
    Flush = 1'b1;
    Issue_Valid = 1'b1; Issue_Addr = 5'd9;
    Reg_Write = 1'b1; W_Addr = 5'd7;
    W_Data = 32'hA5A5A5A5;
    tick();
    idle();
    R_Addr = {5'd9, 5'd7};
    #1;
    total++;
    if (Busy_Count !== 6'd0) begin
      bad++;
      $display("FAIL fl_count got=%0d exp=0", Busy_Count);
    end
    total++;
    if (R_Busy !== 2'b00) begin
      bad++;
      $display("FAIL fl_busy got=%b exp=00", R_Busy);
    end
    total++;
    if (R_Data[31:0] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL fl_write got=%h exp=A5A5A5A5", R_Data[31:0]);
    end
    R_Addr = {5'd3, 5'd3};
    #1;
    total++;
    if (R_Busy !== 2'b00) begin
      bad++;
      $display("FAIL fl_r3 got=%b exp=00", R_Busy);
    end
  endtask

  task automatic test_back_to_back();
    Reg_Write = 1'b1; W_Addr = 5'd10;
    W_Data = 32'h1;
    tick();
    W_Data = 32'h2;
    tick();
    idle();
    R_Addr = {5'd10, 5'd10};
    #1;
    total++;
    if (R_Data !== {32'h2, 32'h2}) begin
      bad++;
      $display("FAIL b2b_last got=%h exp=0000000200000002", R_Data);
    end
  endtask

  task automatic test_mid_reset();
    Reg_Write = 1'b1; W_Addr = 5'd2;
    W_Data = 32'hCAFEF00D;
    Issue_Valid = 1'b1; Issue_Addr = 5'd6;
    tick();
    idle();
    R_Addr = {5'd6, 5'd2};
    #1;
    total++;
    if (R_Data[31:0] !== 32'hCAFEF00D || R_Busy !== 2'b10
        || Busy_Count !== 6'd1) begin
      bad++;
      $display("FAIL mr_pre got=%h/%b/%0d exp=CAFEF00D/10/1",
               R_Data[31:0], R_Busy, Busy_Count);
    end
    rst = 1'b1;
    #1;
    total++;
    if (R_Data !== 64'd0) begin
      bad++;
      $display("FAIL mr_data got=%h exp=0", R_Data);
    end
    total++;
    if (R_Busy !== 2'b00) begin
      bad++;
      $display("FAIL mr_busy got=%b exp=00", R_Busy);
    end
    total++;
    if (Busy_Count !== 6'd0) begin
      bad++;
      $display("FAIL mr_count got=%0d exp=0", Busy_Count);
    end
    rst = 1'b0;
    Reg_Write = 1'b1; W_Addr = 5'd2;
    W_Data = 32'h5;
    tick();
    idle();
    #1;
    total++;
    if (R_Data[31:0] !== 32'h5) begin
      bad++;
      $display("FAIL mr_after got=%h exp=5", R_Data[31:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    W_Addr = '0; W_Data = '0;
    R_Addr = '0; Issue_Addr = '0;
    test_reset();
    test_write_read();
    test_zero();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
